// File: rtl/seg_disp_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
// Latency: n/a (constants, types and a combinational helper only).
// Backpressure: n/a.
package seg_disp_pkg;

    // Code that the downstream decoder renders as all segments off.
    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Widest display the scanner supports.
    localparam int MAX_DIGITS = 8;
    localparam int SEL_IDX_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_e;

    // One-hot digit enable for a digit index; the caller truncates to its width.
    function automatic logic [MAX_DIGITS-1:0] onehot(input logic [SEL_IDX_W-1:0] idx);
        logic [MAX_DIGITS-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Digit-dwell prescaler: counts 0..REFRESH_DIV-1 while run is high, held at 0 otherwise.
// Latency: tick is a decode of the registered count, asserted in the last cycle of each dwell.
// Backpressure: none; free-running whenever run is high.
module scan_tick_gen
    import seg_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: cleared when stopped, wraps at the end of each dwell.
    always_comb begin
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = run && (cnt_q == CNT_LAST);

endmodule

// File: rtl/bcd_digit_scanner.sv
// Multiplexed seven-segment scan controller with tear-free frame updates and leading-zero blanking.
// Latency: bcd_out/digit_sel follow idx/disp by one cycle; frame_tick lands with the return to digit 0.
// Backpressure: none; loads are always accepted, the last load before a frame boundary wins.
module bcd_digit_scanner
    import seg_disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    blank_lz,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_tick
);

    localparam int DW    = 4 * NUM_DIGITS;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    scan_state_e           state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DW-1:0]         disp_q, disp_d;
    logic [DW-1:0]         pend_q, pend_d;
    logic                  pend_vld_q, pend_vld_d;
    logic                  bnd_q, bnd_d;
    logic [3:0]            bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic                  ftick_q, ftick_d;

    logic                  tick;
    logic                  boundary;
    logic                  zero_run;
    logic [NUM_DIGITS-1:0] blank_mask;
    logic [SEL_IDX_W-1:0]  idx_ext;

    scan_tick_gen #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .run  (enable),
        .tick (tick)
    );

    assign boundary = tick && (idx_q == IDX_LAST);
    assign idx_ext  = SEL_IDX_W'(idx_q);

    // Leading-zero mask: a digit blanks when it and all digits above it are zero; digit 0 never blanks.
    always_comb begin
        zero_run   = 1'b1;
        blank_mask = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run      = zero_run && (disp_q[4*k +: 4] == 4'h0);
            blank_mask[k] = blank_lz && (k != 0) && zero_run;
        end
    end

    // Control FSM, scan index, frame double-buffer and registered output selection.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        disp_d     = disp_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        bnd_d      = boundary;
        bcd_d      = BLANK_CODE;
        sel_d      = '0;
        ftick_d    = 1'b0;

        case (state_q)
            IDLE:    if (enable)  state_d = SCAN;
            SCAN:    if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (!enable) begin
            idx_d = '0;
        end else if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // A load on the boundary bypasses the pending buffer; otherwise pending data
        // moves on a boundary, or at once while stopped. A fresh load re-arms pending.
        if (load && boundary) begin
            disp_d     = digits_in;
            pend_vld_d = 1'b0;
        end else begin
            if (pend_vld_q && (boundary || !enable)) begin
                disp_d     = pend_q;
                pend_vld_d = 1'b0;
            end
            if (load) begin
                pend_d     = digits_in;
                pend_vld_d = 1'b1;
            end
        end

        // Digit enable and code are built from the same index so they always switch together.
        if (state_d == SCAN) begin
            sel_d   = NUM_DIGITS'(onehot(idx_ext));
            bcd_d   = blank_mask[idx_q] ? BLANK_CODE : disp_q[{idx_q, 2'b00} +: 4];
            ftick_d = bnd_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            disp_q     <= {NUM_DIGITS{BLANK_CODE}};
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            bnd_q      <= 1'b0;
            bcd_q      <= BLANK_CODE;
            sel_q      <= '0;
            ftick_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            disp_q     <= disp_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            bnd_q      <= bnd_d;
            bcd_q      <= bcd_d;
            sel_q      <= sel_d;
            ftick_q    <= ftick_d;
        end
    end

    assign bcd_out    = bcd_q;
    assign digit_sel  = sel_q;
    assign frame_tick = ftick_q;

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Directed bench for bcd_digit_scanner with a 4-digit display and a 4-cycle dwell.
// Latency: outputs sampled on the falling edge after each rising edge.
// Backpressure: n/a.
module tb_bcd_digit_scanner;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] digits_in;
    logic        blank_lz;
    logic [3:0]  bcd_out;
    logic [3:0]  digit_sel;
    logic        frame_tick;

    int n_checks;
    int n_fail;

    bcd_digit_scanner #(
        .NUM_DIGITS (4),
        .REFRESH_DIV(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .load      (load),
        .digits_in (digits_in),
        .blank_lz  (blank_lz),
        .bcd_out   (bcd_out),
        .digit_sel (digit_sel),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_blank(input string tag);
        check({tag, " sel"}, 32'(digit_sel), 32'h0);
        check({tag, " bcd"}, 32'(bcd_out), 32'hF);
        check({tag, " ftick"}, 32'(frame_tick), 32'h0);
    endtask

    // One digit dwell: 4 cycles showing digit d; optional single-cycle load at step ld_step.
    task automatic scan_digit(input int d, input logic [3:0] expv, input bit ft_first,
                              input int ld_step, input logic [15:0] ld_data);
        for (int c = 0; c < 4; c++) begin
            if (c == ld_step) begin
                load      = 1'b1;
                digits_in = ld_data;
            end
            step();
            load = 1'b0;
            check($sformatf("sel d%0d c%0d", d, c), 32'(digit_sel), 32'(1 << d));
            check($sformatf("bcd d%0d c%0d", d, c), 32'(bcd_out), 32'(expv));
            check($sformatf("ftick d%0d c%0d", d, c), 32'(frame_tick), 32'(ft_first && (c == 0)));
        end
    endtask

    // A full frame; exp holds the expected shown code of digit k at bits [4k+3:4k].
    task automatic scan_frame(input logic [15:0] exp, input bit ft);
        for (int d = 0; d < 4; d++) begin
            scan_digit(d, exp[4*d +: 4], ft && (d == 0), -1, 16'h0);
        end
    endtask

    // Load while stopped: pending data reaches disp one edge after the load.
    task automatic idle_load(input logic [15:0] data);
        enable    = 1'b0;
        load      = 1'b1;
        digits_in = data;
        step();
        load = 1'b0;
        check_blank("idle_load");
        step();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        enable    = 1'b0;
        load      = 1'b0;
        digits_in = 16'h0;
        blank_lz  = 1'b0;
        rst_n     = 1'b1;

        // Reset: outputs blank during and after reset while disabled.
        #2 rst_n = 1'b0;
        #1 check_blank("in_reset");
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_blank("post_reset");
        end

        // Basic scan of 1234, two frames; the second starts with frame_tick.
        idle_load(16'h1234);
        enable = 1'b1;
        scan_frame(16'h1234, 1'b0);
        scan_frame(16'h1234, 1'b1);

        // Leading-zero blanking.
        idle_load(16'h0070);
        blank_lz = 1'b1;
        enable   = 1'b1;
        scan_frame(16'hFF70, 1'b0);
        blank_lz = 1'b0;
        scan_frame(16'h0070, 1'b1);
        idle_load(16'h0000);
        blank_lz = 1'b1;
        enable   = 1'b1;
        scan_frame(16'hFFF0, 1'b0);

        // Tear-free update: loads mid-frame never disturb the current frame; last load wins.
        idle_load(16'h1234);
        blank_lz = 1'b0;
        enable   = 1'b1;
        scan_digit(0, 4'h4, 1'b0, -1, 16'h0);
        scan_digit(1, 4'h3, 1'b0, 0, 16'h5678);
        scan_digit(2, 4'h2, 1'b0, 0, 16'h9999);
        scan_digit(3, 4'h1, 1'b0, -1, 16'h0);
        scan_digit(0, 4'h9, 1'b1, -1, 16'h0);
        scan_digit(1, 4'h9, 1'b0, -1, 16'h0);
        scan_digit(2, 4'h9, 1'b0, -1, 16'h0);
        // Load exactly on the boundary edge goes straight to the next frame.
        scan_digit(3, 4'h9, 1'b0, 3, 16'h4321);
        scan_digit(0, 4'h1, 1'b1, -1, 16'h0);

        // Drop enable mid-digit, then restart from digit 0 with a full dwell.
        step();
        check("mid sel", 32'(digit_sel), 32'h2);
        check("mid bcd", 32'(bcd_out), 32'h2);
        enable = 1'b0;
        step();
        check_blank("disabled");
        step();
        check_blank("disabled_hold");
        enable = 1'b1;
        scan_frame(16'h4321, 1'b0);

        // Async reset mid-frame with a pending load outstanding.
        scan_digit(0, 4'h1, 1'b1, -1, 16'h0);
        scan_digit(1, 4'h2, 1'b0, 0, 16'h1111);
        rst_n  = 1'b0;
        enable = 1'b0;
        #1 check_blank("async_reset");
        step();
        check_blank("reset_hold");
        rst_n = 1'b1;
        step();
        check_blank("reset_release");
        enable = 1'b1;
        scan_frame(16'hFFFF, 1'b0);
        scan_frame(16'hFFFF, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_digit_scanner.md
# bcd_digit_scanner

Time-multiplexed scan controller for a multi-digit common-cathode/anode seven-segment display. It holds a frame of packed BCD digits and presents one digit at a time on a 4-bit BCD output to the downstream combinational BCD-to-seven-segment decoder. It also drives a one-hot digit-select bus, applies leading-zero blanking, and swaps in new data only at frame boundaries so the display never tears.

## Interface
- NUM_DIGITS, 4: number of display digits (2..8); digit 0 is least significant.
- REFRESH_DIV, 50000: clock cycles each digit stays selected (>=2).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  scan enable; low blanks the display.
- load  in  1  single-cycle strobe; captures digits_in.
- digits_in  in  4*NUM_DIGITS  packed BCD; digit k at bits [4k+3:4k].
- blank_lz  in  1  leading-zero blanking enable.
- bcd_out  out  4  BCD code to the decoder; 4'hF = blank (decoder drives all segments off for codes >= 10).
- digit_sel  out  NUM_DIGITS  one-hot active-high digit enable.
- frame_tick  out  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to digit 0.

## Operation
- Registers: `pend` (pending frame), `pend_valid`, `disp` (displayed frame), prescaler `cnt` (0..REFRESH_DIV-1), digit index `idx` (0..NUM_DIGITS-1).
- A `load` writes digits_in into `pend` and sets `pend_valid`. When a `load` arrives with `pend_valid` already set, the new data overwrites `pend`; the last load wins.
- Frame boundary: cnt==REFRESH_DIV-1 with idx==NUM_DIGITS-1. At the boundary, if `pend_valid` is set, `disp` <= `pend` and `pend_valid` clears.
- If `load` coincides with the boundary, digits_in goes straight to `disp` and `pend_valid` clears.
- enable=1:
  - `cnt` increments each cycle and wraps at REFRESH_DIV-1.
  - On wrap, `idx` increments modulo NUM_DIGITS.
- enable=0:
  - `cnt` and `idx` are held at 0.
  - Any pending data transfers to `disp` immediately, on the next edge.
- Leading-zero blanking, when blank_lz=1: digit k is blanked if it and every digit above it in `disp` equal 0. Digit 0 is never blanked by this rule.
- Non-decimal codes 4'hA..4'hE in `disp` pass through unchanged.
- Two-state control: SCAN and IDLE.
  - IDLE->SCAN when enable=1.
  - SCAN->IDLE when enable=0.
  - Reset state is IDLE.

## Timing
- All outputs are registered.
- Reset values:
  - bcd_out=4'hF, digit_sel=0, frame_tick=0.
  - `disp` = all 4'hF, `pend_valid`=0, cnt=0, idx=0.
- Output latency: bcd_out/digit_sel reflect idx/`disp` one cycle after they change. bcd_out and digit_sel always switch on the same edge, so there is no mismatched digit/segment pair.
- In SCAN, digit_sel = onehot(idx) and bcd_out = blanked-or-`disp`[idx]. In IDLE, digit_sel=0 and bcd_out=4'hF.
- frame_tick is asserted in the cycle after the boundary edge, aligned with digit_sel returning to digit 0.
- Each digit is held for exactly REFRESH_DIV cycles, so a frame takes NUM_DIGITS*REFRESH_DIV cycles.
- Load to visible, while scanning: between 1 and NUM_DIGITS*REFRESH_DIV+1 cycles.
- Load to visible, while idle: `disp` updates 1 cycle after the load, and the new data is visible once enable rises.
- Reset asserted mid-frame returns every register to its reset value immediately; pending data is discarded.

## Structure
- Shared package `seg_disp_pkg`:
  - BLANK_CODE = 4'hF.
  - State enum {IDLE, SCAN}.
  - Function `onehot(idx)`.
- Sub-module `scan_tick_gen`:
  - Parameterised prescaler holding `cnt`.
  - Inputs: clk, rst_n, run.
  - Output: `tick` at cnt==REFRESH_DIV-1.
- The top level instantiates no decoder; the decoder is a separate downstream block.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4.
- Reset: release rst_n with enable=0 -> bcd_out=4'hF, digit_sel=4'b0000, frame_tick=0, held indefinitely.
- Basic scan: load digits_in=16'h1234, then enable=1 -> sequence 4,3,2,1 on bcd_out with digit_sel 0001,0010,0100,1000, each held 4 cycles. frame_tick pulses once per 16 cycles, concurrent with digit_sel=0001.
- Leading-zero blanking: disp=16'h0070, blank_lz=1 -> bcd_out per digit 0,7,F,F. With blank_lz=0 -> 0,7,0,0. With disp=16'h0000 and blank_lz=1 -> 0,F,F,F.
- Tear-free update: while scanning 16'h1234, load 16'h5678 when idx=1, then load 16'h9999 when idx=2 -> digits 2 and 3 still show 2,1. The next frame shows 9,9,9,9; 5678 never appears.
- Boundary coincidence and disable: load 16'h4321 exactly at the boundary cycle -> the next frame shows 1,2,3,4. Drop enable mid-digit -> digit_sel=0 and bcd_out=F next cycle. Re-enable -> the scan restarts at digit 0 with a full 4-cycle dwell.
- Async reset mid-frame with `pend_valid` set -> outputs go to reset values with no clock edge. After release and enable, all digits show 4'hF (pending data discarded).
